// File: rtl/vc_domain_arb4.sv
// Four-requester round-robin arbiter feeding the domain-labelled 4:1 mux.
// Inserts p_switch_gap idle cycles whenever the granted domain changes.
module vc_domain_arb4 #(
    parameter int unsigned p_switch_gap = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_val,
    input  logic [3:0] req_domain,
    output logic [3:0] req_rdy,
    output logic [1:0] sel,
    output logic       domain,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [1:0] dbg_state,
    output logic [1:0] dbg_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    localparam logic [1:0] GAP_INIT = 2'(p_switch_gap);
    localparam logic       GAP_EN   = (p_switch_gap > 0);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] g_q, g_d;
    logic       dom_q, dom_d;
    logic       last_dom_q, last_dom_d;
    logic [1:0] gap_cnt_q, gap_cnt_d;

    logic       fire;
    logic       arb_en;
    logic [3:0] arb_vec;
    logic [1:0] arb_ptr;
    logic       cmp_dom;
    logic [2:0] win;

    // Returns {found, index}: first set bit of v scanning p, p+1, p+2, p+3.
    function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            g_q        <= 2'd0;
            dom_q      <= 1'b0;
            last_dom_q <= 1'b0;
            gap_cnt_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            dom_q      <= dom_d;
            last_dom_q <= last_dom_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        dom_d      = dom_q;
        last_dom_d = last_dom_q;
        gap_cnt_d  = gap_cnt_q;
        arb_en     = 1'b0;
        arb_vec    = req_val;
        arb_ptr    = ptr_q;
        cmp_dom    = last_dom_q;
        fire       = (state_q == ST_GRANT) && req_val[g_q] && out_rdy;

        case (state_q)
            ST_IDLE: arb_en = 1'b1;
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 2'd1;
                if (gap_cnt_q == 2'd1) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                // On accept, re-arbitrate immediately so same-domain traffic streams without bubbles.
                if (fire) begin
                    last_dom_d = dom_q;
                    ptr_d      = g_q + 2'd1;
                    arb_en     = 1'b1;
                    arb_vec    = req_val & ~(4'b0001 << g_q);
                    arb_ptr    = g_q + 2'd1;
                    cmp_dom    = dom_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        win = rr_pick(arb_vec, arb_ptr);
        if (arb_en && win[2]) begin
            g_d   = win[1:0];
            dom_d = req_domain[win[1:0]];
            if ((dom_d != cmp_dom) && GAP_EN) begin
                gap_cnt_d = GAP_INIT;
                state_d   = ST_GAP;
            end else begin
                state_d = ST_GRANT;
            end
        end
    end

    // Handshake: a transfer happens on a cycle where out_val and out_rdy are both high;
    // req_rdy[g] mirrors out_rdy combinationally so the requester sees the same accept.
    always_comb begin
        out_val   = (state_q == ST_GRANT) && req_val[g_q];
        req_rdy   = 4'b0000;
        if (state_q == ST_GRANT) req_rdy[g_q] = out_rdy;
        sel       = g_q;
        domain    = dom_q;
        dbg_state = state_q;
        dbg_ptr   = ptr_q;
    end

endmodule

// File: tb/tb_vc_domain_arb4.sv
// Bench for vc_domain_arb4: per-cycle vector table on a gap-2 instance and a
// scoreboarded transfer stream on a gap-0 instance.
module tb_vc_domain_arb4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] req_val, req_domain, req_rdy;
    logic [1:0] sel, dbg_state, dbg_ptr;
    logic       domain, out_val, out_rdy;

    logic [3:0] req_val_z, req_domain_z, req_rdy_z;
    logic [1:0] sel_z, dbg_state_z, dbg_ptr_z;
    logic       domain_z, out_val_z, out_rdy_z;

    vc_domain_arb4 #(.p_switch_gap(2)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_domain(req_domain),
        .req_rdy(req_rdy), .sel(sel), .domain(domain), .out_val(out_val),
        .out_rdy(out_rdy), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    vc_domain_arb4 #(.p_switch_gap(0)) dut0 (
        .clk(clk), .reset(reset), .req_val(req_val_z), .req_domain(req_domain_z),
        .req_rdy(req_rdy_z), .sel(sel_z), .domain(domain_z), .out_val(out_val_z),
        .out_rdy(out_rdy_z), .dbg_state(dbg_state_z), .dbg_ptr(dbg_ptr_z)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] val;
        logic [3:0] dom;
        logic       rdy;
        logic       e_val;
        logic [1:0] e_sel;
        logic       e_dom;
        logic [3:0] e_rdy;
        logic [1:0] e_ptr;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] d, input logic rd,
                       input logic ev, input logic [1:0] es, input logic ed,
                       input logic [3:0] er, input logic [1:0] ep);
        vec_t t;
        t.rst_n = r; t.val = v; t.dom = d; t.rdy = rd;
        t.e_val = ev; t.e_sel = es; t.e_dom = ed; t.e_rdy = er; t.e_ptr = ep;
        vecs.push_back(t);
    endtask

    // Scoreboard for the gap-0 instance: every accepted transfer pops one {sel, domain}.
    always @(negedge clk) begin
        if (reset && out_val_z && out_rdy_z) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got sel=%0d dom=%0d expected no transfer", sel_z, domain_z);
            end else begin
                chk("sb_xfer", 8'({sel_z, domain_z}), 8'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_z(input int idx, input logic d);
        logic accepted;
        accepted = 1'b0;
        @(posedge clk); #1;
        req_val_z    = 4'(1 << idx);
        req_domain_z = {4{d}};
        exp_q.push_back({2'(idx), d});
        for (int c = 0; c < 30; c++) begin
            out_rdy_z = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_val_z && req_rdy_z[idx]) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no accept for requester %0d expected accept within 30 cycles", idx);
        end
        @(posedge clk); #1;
        req_val_z = 4'b0000;
        out_rdy_z = 1'b0;
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int n_cyc;
        reset = 1'b0;
        req_val = 4'b0; req_domain = 4'b0; out_rdy = 1'b0;
        req_val_z = 4'b0; req_domain_z = 4'b0; out_rdy_z = 1'b0;

        // single requester, pointer advance
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0001, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0001, 4'b0000, 1, 1, 0, 0, 4'b0001, 0);
        add(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 1);
        // four requesters, same domain: 0,1,2,3,0 with wrap
        add(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 1, 1, 0, 0, 4'b0001, 0);
        add(1, 4'b1111, 4'b0000, 1, 1, 1, 0, 4'b0010, 1);
        add(1, 4'b1111, 4'b0000, 1, 1, 2, 0, 4'b0100, 2);
        add(1, 4'b1111, 4'b0000, 1, 1, 3, 0, 4'b1000, 3);
        add(1, 4'b1111, 4'b0000, 1, 1, 0, 0, 4'b0001, 0);
        // domain switch with a 2-cycle gap, out_rdy low in the gap
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0001, 4'b0000, 1, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0011, 4'b0010, 1, 1, 0, 0, 4'b0001, 0);
        add(1, 4'b0010, 4'b0010, 1, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0010, 4'b0010, 0, 0, 1, 1, 4'b0000, 1);
        add(1, 4'b0010, 4'b0010, 1, 1, 1, 1, 4'b0010, 1);
        add(1, 4'b0000, 4'b0000, 1, 0, 1, 1, 4'b0000, 2);
        // stall 5 cycles while requester 2 waits
        add(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0101, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        for (int i = 0; i < 5; i++) add(1, 4'b0101, 4'b0000, 0, 1, 0, 0, 4'b0000, 0);
        add(1, 4'b0101, 4'b0000, 1, 1, 0, 0, 4'b0001, 0);
        add(1, 4'b0100, 4'b0000, 1, 1, 2, 0, 4'b0100, 1);
        add(1, 4'b0000, 4'b0000, 0, 0, 2, 0, 4'b0000, 3);
        // build nonzero ptr and last_dom=1, then reset during GRANT
        add(1, 4'b1000, 4'b1000, 0, 0, 2, 0, 4'b0000, 3);
        add(1, 4'b1000, 4'b1000, 0, 0, 3, 1, 4'b0000, 3);
        add(1, 4'b1000, 4'b1000, 0, 0, 3, 1, 4'b0000, 3);
        add(1, 4'b1000, 4'b1000, 1, 1, 3, 1, 4'b1000, 3);
        add(1, 4'b0010, 4'b0010, 0, 0, 3, 1, 4'b0000, 0);
        add(1, 4'b0110, 4'b0110, 1, 1, 1, 1, 4'b0010, 0);
        add(1, 4'b0100, 4'b0100, 0, 1, 2, 1, 4'b0000, 2);
        add(0, 4'b0100, 4'b0100, 1, 0, 0, 0, 4'b0000, 0);
        // after reset: ptr=0 picks requester 0, last_dom=0 forces a gap
        add(1, 4'b0101, 4'b0101, 1, 0, 0, 0, 4'b0000, 0);
        add(1, 4'b0101, 4'b0101, 1, 0, 0, 1, 4'b0000, 0);
        add(1, 4'b0101, 4'b0101, 0, 0, 0, 1, 4'b0000, 0);
        add(1, 4'b0101, 4'b0101, 1, 1, 0, 1, 4'b0001, 0);
        add(1, 4'b0100, 4'b0100, 1, 1, 2, 1, 4'b0100, 1);
        add(1, 4'b0000, 4'b0000, 0, 0, 2, 1, 4'b0000, 3);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            reset      = vecs[i].rst_n;
            req_val    = vecs[i].val;
            req_domain = vecs[i].dom;
            out_rdy    = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d.out_val", i), 8'(out_val), 8'(vecs[i].e_val));
            chk($sformatf("v%0d.sel", i),     8'(sel),     8'(vecs[i].e_sel));
            chk($sformatf("v%0d.domain", i),  8'(domain),  8'(vecs[i].e_dom));
            chk($sformatf("v%0d.req_rdy", i), 8'(req_rdy), 8'(vecs[i].e_rdy));
            chk($sformatf("v%0d.ptr", i),     8'(dbg_ptr), 8'(vecs[i].e_ptr));
        end

        // gap-0 instance: alternating domains stream one transfer per cycle
        @(posedge clk); #1;
        reset = 1'b0; req_val = 4'b0; out_rdy = 1'b0;
        @(posedge clk); #1;
        reset        = 1'b1;
        req_val_z    = 4'b1111;
        req_domain_z = 4'b1010;
        out_rdy_z    = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back({2'(k % 4), 1'(k % 2)});
        n_cyc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            n_cyc++;
            if (exp_q.size() == 0) break;
        end
        chk("alt_left", 8'(exp_q.size()), 8'd0);
        chk("alt_cycles", 8'(n_cyc), 8'd9);
        exp_q.delete();

        @(posedge clk); #1;
        reset = 1'b0; req_val_z = 4'b0; out_rdy_z = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int t = 0; t < 8; t++) send_z(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        @(negedge clk); #1;
        chk("sb_drain", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
